// File: rtl/ifq_pkg.sv
// ifq_pkg
//   Shared definitions for the instruction fetch queue: the NOP word shown
//   to ID when nothing is valid, the default address width, the width
//   helper for occupancy counters and the {pc, inst} queue entry type.
package ifq_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [31:0]         inst;
   } ifq_entry_t;

   // Width of a counter that must hold every value 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo
//   Synchronous DEPTH-entry FIFO of {pc, inst} pairs with a single-cycle
//   clear that overrides push and pop.
// Ports:
//   clk, reset (async, active low)
//   clear               drop every entry this cycle
//   push, push_pc/inst  write one entry at the tail
//   pop                 consume the head (ignored when empty)
//   head_pc/inst        current head entry (undefined when empty)
//   count, empty, full  occupancy
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      push,
   input  logic [XLEN-1:0]           push_pc,
   input  logic [31:0]               push_inst,
   input  logic                      pop,
   output logic [XLEN-1:0]           head_pc,
   output logic [31:0]               head_inst,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      empty,
   output logic                      full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop && !empty;
   assign head_pc   = pc_mem[rd_ptr];
   assign head_inst = inst_mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap without compare logic.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !do_pop)
            count <= count + CW'(1);
         else if (!push && do_pop)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         pc_mem[wr_ptr]   <= push_pc;
         inst_mem[wr_ptr] <= push_inst;
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Decoupled instruction fetch front end: issues in-order requests to a
//   variable-latency instruction memory, buffers up to DEPTH returned
//   instructions with their PCs and presents the head to ID. A taken
//   branch/jump clears the queue, redirects fetch and discards responses
//   still in flight.
// Ports:
//   clk, reset (async, active low)
//   br_ctrl, br_dst         redirect request and target from EX
//   stall                   ID cannot take the head this cycle
//   imem_req_*              request handshake (valid/ready/addr)
//   imem_resp_*             in-order response strobe and instruction
//   id_valid/id_pc/id_inst  queue head to ID (NOP when not valid)
//   ifq_count               occupied queue entries
// Build option:
//   IFQ_BYPASS_EN  a response arriving at an empty queue drives the ID
//                  outputs in the same cycle instead of one cycle later.
module inst_fetch_queue
   import ifq_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     br_ctrl,
   input  logic [XLEN-1:0]          br_dst,
   input  logic                     stall,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [XLEN-1:0]          imem_req_addr,
   input  logic                     imem_resp_valid,
   input  logic [31:0]              imem_resp_data,
   output logic                     id_valid,
   output logic [XLEN-1:0]          id_pc,
   output logic [31:0]              id_inst,
   output logic [cnt_w(DEPTH)-1:0]  ifq_count
);

   localparam int unsigned CW = cnt_w(DEPTH);

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] rpc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   out_next;
   logic [XLEN-1:0] dst;
   logic [CW:0]     credit_used;
   logic            fire;
   logic            resp_take;
   logic            resp_drop;
   logic            pop_ok;
   logic            bypass;
   logic            fifo_push;
   logic            fifo_pop;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_inst;
   logic            fifo_empty;
   logic            fifo_full;

   assign dst         = br_dst & ~XLEN'(3);
   assign credit_used = {1'b0, ifq_count} + {1'b0, outstanding};

   // Gating with reset keeps the request low while reset is held and lets
   // it rise in the very first cycle after release.
   assign imem_req_valid = reset && !br_ctrl && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fpc;
   assign fire           = imem_req_valid && imem_req_ready;

   assign resp_drop = imem_resp_valid && (drop_cnt != '0);
   assign resp_take = imem_resp_valid && (drop_cnt == '0);
   assign pop_ok    = !stall && !br_ctrl;

`ifdef IFQ_BYPASS_EN
   assign bypass = resp_take && fifo_empty;
   always_comb begin
      id_valid = !fifo_empty || bypass;
      id_pc    = '0;
      id_inst  = NOP_INST;
      if (!fifo_empty) begin
         id_pc   = head_pc;
         id_inst = head_inst;
      end else if (bypass) begin
         id_pc   = rpc;
         id_inst = imem_resp_data;
      end
   end
`else
   assign bypass = 1'b0;
   always_comb begin
      id_valid = !fifo_empty;
      id_pc    = '0;
      id_inst  = NOP_INST;
      if (!fifo_empty) begin
         id_pc   = head_pc;
         id_inst = head_inst;
      end
   end
`endif

   // A bypassed response that ID takes immediately never enters the queue.
   assign fifo_push = resp_take && !br_ctrl && !(bypass && pop_ok);
   assign fifo_pop  = !fifo_empty && pop_ok;

   always_comb begin
      out_next = outstanding;
      if (fire && !imem_resp_valid)
         out_next = outstanding + CW'(1);
      else if (!fire && imem_resp_valid)
         out_next = outstanding - CW'(1);
   end

   // On redirect no request fires, so out_next already excludes a response
   // arriving this cycle: that response is treated as dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc         <= RESET_PC;
         rpc         <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= out_next;
         if (br_ctrl) begin
            fpc      <= dst;
            rpc      <= dst;
            drop_cnt <= out_next;
         end else begin
            if (fire)
               fpc <= fpc + XLEN'(4);
            if (resp_take)
               rpc <= rpc + XLEN'(4);
            if (resp_drop)
               drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && !br_ctrl)
         assert (!(fifo_push && fifo_full && !fifo_pop));
   end

   ifq_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (br_ctrl),
      .push      (fifo_push),
      .push_pc   (rpc),
      .push_inst (imem_resp_data),
      .pop       (fifo_pop),
      .head_pc   (head_pc),
      .head_inst (head_inst),
      .count     (ifq_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule
